// File: rtl/npc_stage_ctrl.sv
// Multi-cycle FETCH/WAIT/DECODE/EXEC/WB sequencer for the NPC core; owns PC, IR and the imem handshake.
// Optional macro NPC_PERF_CNT_EN adds 64-bit cycle and retired-instruction counters.
module npc_stage_ctrl #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned           FETCH_TMO  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [DATA_WIDTH-1:0] pc,
   output logic                  id_en,
   output logic                  ex_start,
   input  logic                  ex_done,
   input  logic [DATA_WIDTH-1:0] next_pc,
   input  logic                  wb_req,
   output logic                  rf_we,
   output logic                  halt,
   output logic                  halt_err,
   output logic [63:0]           perf_cycles,
   output logic [63:0]           perf_instret
);

   localparam int unsigned           TmoW    = (FETCH_TMO > 1) ? $clog2(FETCH_TMO) : 1;
   localparam logic [TmoW-1:0]       TmoLast = TmoW'(FETCH_TMO - 1);
   localparam logic [DATA_WIDTH-1:0] Ebreak  = DATA_WIDTH'(32'h0010_0073);

   typedef enum logic [2:0] {
      StFetch,
      StWait,
      StDecode,
      StExec,
      StWb,
      StHalt
   } state_e;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   pc_q;
   logic [DATA_WIDTH-1:0]   inst_q;
   logic [TmoW-1:0]         tmo_cnt_q;
   logic                    req_valid_q;
   logic                    id_en_q;
   logic                    ex_start_q;
   logic                    halt_q;
   logic                    halt_err_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:  if (imem_req_ready) state_d = StWait;
         // A response on the final timeout cycle takes priority over the halt.
         StWait: begin
            if (imem_rsp_valid) begin
               state_d = StDecode;
            end else if (tmo_cnt_q == TmoLast) begin
               state_d = StHalt;
            end
         end
         StDecode: state_d = (inst_q == Ebreak) ? StHalt : StExec;
         StExec:   if (ex_done) state_d = StWb;
         StWb:     state_d = StFetch;
         StHalt:   state_d = StHalt;
         default:  state_d = StHalt;
      endcase
   end

   // Outputs that depend only on state are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFetch;
         pc_q        <= RESET_PC;
         inst_q      <= '0;
         tmo_cnt_q   <= '0;
         req_valid_q <= 1'b1;
         id_en_q     <= 1'b0;
         ex_start_q  <= 1'b0;
         halt_q      <= 1'b0;
         halt_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= (state_d == StFetch);
         id_en_q     <= (state_d == StDecode);
         ex_start_q  <= (state_q == StDecode) && (state_d == StExec);
         halt_q      <= (state_d == StHalt);
         if (state_q == StWait) begin
            if (imem_rsp_valid) begin
               inst_q    <= imem_rdata;
               tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == TmoLast) begin
               halt_err_q <= 1'b1;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
         end
         if (state_q == StWb) begin
            pc_q <= next_pc;
         end
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign inst           = inst_q;
   assign id_en          = id_en_q;
   assign ex_start       = ex_start_q;
   assign halt           = halt_q;
   assign halt_err       = halt_err_q;
   // wb_req is only meaningful while in WB, so the write enable follows it directly.
   assign rf_we          = (state_q == StWb) && wb_req && !rst;

`ifdef NPC_PERF_CNT_EN
   logic [63:0] cycles_q;
   logic [63:0] instret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycles_q  <= '0;
         instret_q <= '0;
      end else begin
         cycles_q <= cycles_q + 64'd1;
         if (state_q == StWb) begin
            instret_q <= instret_q + 64'd1;
         end
      end
   end

   assign perf_cycles  = cycles_q;
   assign perf_instret = instret_q;
`else
   assign perf_cycles  = '0;
   assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_npc_stage_ctrl.sv
// Directed bench for npc_stage_ctrl built with FETCH_TMO=4.
module tb_npc_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        id_en;
   logic        ex_start;
   logic        ex_done;
   logic [31:0] next_pc;
   logic        wb_req;
   logic        rf_we;
   logic        halt;
   logic        halt_err;
   logic [63:0] perf_cycles;
   logic [63:0] perf_instret;

   int n_chk  = 0;
   int n_fail = 0;

   npc_stage_ctrl #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h8000_0000),
      .FETCH_TMO  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .inst           (inst),
      .pc             (pc),
      .id_en          (id_en),
      .ex_start       (ex_start),
      .ex_done        (ex_done),
      .next_pc        (next_pc),
      .wb_req         (wb_req),
      .rf_we          (rf_we),
      .halt           (halt),
      .halt_err       (halt_err),
      .perf_cycles    (perf_cycles),
      .perf_instret   (perf_instret)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_instr(input logic [31:0] npc);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'h0000_0013;
      tick();
      imem_rsp_valid = 1'b0;
      tick();
      ex_done = 1'b1;
      wb_req  = 1'b1;
      next_pc = npc;
      tick();
      ex_done = 1'b0;
      wb_req  = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
      ex_done = 1'b0; next_pc = '0; wb_req = 1'b0;
      tick();
      chk("rst_req_valid", imem_req_valid, 1);
      chk("rst_addr", imem_addr, 64'h8000_0000);
      chk("rst_inst", inst, 0);
      chk("rst_id_en", id_en, 0);
      chk("rst_ex_start", ex_start, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_halt", {halt, halt_err}, 0);
      chk("rst_perf", {perf_cycles[31:0], perf_instret[31:0]}, 0);
      rst = 1'b0;

      // 1: zero-wait instruction, back in FETCH after 5 cycles
      imem_req_ready = 1'b1;
      tick();
      chk("t1_wait_req", imem_req_valid, 0);
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'h0000_0013;
      tick();
      chk("t1_dec_id_en", id_en, 1);
      chk("t1_dec_inst", inst, 64'h13);
      imem_rsp_valid = 1'b0;
      tick();
      chk("t1_exec_start", ex_start, 1);
      chk("t1_exec_id_en", id_en, 0);
      ex_done = 1'b1; wb_req = 1'b1; next_pc = 32'h8000_0004;
      tick();
      chk("t1_wb_rf_we", rf_we, 1);
      chk("t1_wb_start", ex_start, 0);
      chk("t1_wb_pc_hold", pc, 64'h8000_0000);
      ex_done = 1'b0; wb_req = 1'b0;
      tick();
      chk("t1_fetch_req", imem_req_valid, 1);
      chk("t1_fetch_addr", imem_addr, 64'h8000_0004);
      chk("t1_fetch_rf_we", rf_we, 0);
`ifdef NPC_PERF_CNT_EN
      chk("t1_instret", perf_instret, 1);
      chk("t1_cycles", perf_cycles, 5);
`endif

      // 2: request stalled by ready=0 for 3 cycles
      for (int i = 0; i < 3; i++) begin
         chk("t2_stall_req", imem_req_valid, 1);
         chk("t2_stall_addr", imem_addr, 64'h8000_0004);
         tick();
      end
      chk("t2_c4_req", imem_req_valid, 1);
      imem_req_ready = 1'b1;
      tick();
      chk("t2_wait_req", imem_req_valid, 0);

      // 3: ebreak halts cleanly and ignores further inputs
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'h0010_0073;
      tick();
      chk("t3_dec_id_en", id_en, 1);
      chk("t3_dec_halt", halt, 0);
      imem_rsp_valid = 1'b0;
      tick();
      chk("t3_halt", halt, 1);
      chk("t3_halt_err", halt_err, 0);
      chk("t3_halt_ex_start", ex_start, 0);
      imem_rsp_valid = 1'b1; imem_rdata = 32'hdead_beef; ex_done = 1'b1; wb_req = 1'b1;
      imem_req_ready = 1'b1; next_pc = 32'h1111_1110;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_abs_halt", halt, 1);
         chk("t3_abs_en", {imem_req_valid, id_en, ex_start, rf_we}, 0);
         chk("t3_abs_inst", inst, 64'h0010_0073);
         chk("t3_abs_pc", pc, 64'h8000_0004);
      end
      imem_rsp_valid = 1'b0; ex_done = 1'b0; wb_req = 1'b0; imem_req_ready = 1'b0;

      // 4a: fetch timeout after 4 WAIT cycles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_rst_halt", {halt, halt_err}, 0);
      chk("t4_rst_pc", pc, 64'h8000_0000);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_wait_nohalt", halt, 0);
      end
      tick();
      chk("t4_tmo_halt", halt, 1);
      chk("t4_tmo_err", halt_err, 1);

      // 4b: response on the 4th WAIT cycle beats the timeout
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4b_rst_err", halt_err, 0);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      imem_rsp_valid = 1'b1; imem_rdata = 32'h0000_0013;
      tick();
      chk("t4b_dec_id_en", id_en, 1);
      chk("t4b_no_halt", {halt, halt_err}, 0);

      // 5: delayed ex_done, wb_req=0, unaligned next_pc taken verbatim
      imem_rsp_valid = 1'b0;
      tick();
      chk("t5_start", ex_start, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_start_once", ex_start, 0);
      end
      ex_done = 1'b1; wb_req = 1'b0; next_pc = 32'h1234_5679;
      tick();
      chk("t5_wb_rf_we", rf_we, 0);
      ex_done = 1'b0;
      tick();
      chk("t5_pc", pc, 64'h1234_5679);
      chk("t5_fetch_req", imem_req_valid, 1);

      // 6: reset while in WAIT, late response ignored in FETCH
      imem_req_ready = 1'b1;
      tick();
      chk("t6_in_wait", imem_req_valid, 0);
      imem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_pc", pc, 64'h8000_0000);
      chk("t6_req", imem_req_valid, 1);
      chk("t6_inst", inst, 0);
      imem_rsp_valid = 1'b1; imem_rdata = 32'hdead_beef;
      tick();
      imem_rsp_valid = 1'b0;
      chk("t6_late_rsp_fetch", {imem_req_valid, id_en}, 2'b10);
      chk("t6_late_rsp_inst", inst, 0);
`ifdef NPC_PERF_CNT_EN
      chk("t6_instret_rst", perf_instret, 0);
`endif
      run_instr(32'h8000_0004);
      run_instr(32'h8000_0008);
      run_instr(32'h8000_000c);
      chk("t6_pc_after3", pc, 64'h8000_000c);
`ifdef NPC_PERF_CNT_EN
      chk("t6_instret3", perf_instret, 3);
      chk("t6_cycles", perf_cycles, 16);
`else
      chk("t6_perf_off", {perf_cycles[31:0], perf_instret[31:0]}, 0);
      chk("t6_perf_off_hi", {perf_cycles[63:32], perf_instret[63:32]}, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
